// File: rtl/bs_pkg.sv
// Shared sizing and channel state type for the bit-serial message buffer.
package bs_pkg;
    localparam int NUM_CH    = 8;
    localparam int MSG_WORDS = 64;
    localparam int CH_W      = 3;
    localparam int WORD_W    = 6;
    localparam int RAM_AW    = CH_W + WORD_W;
    localparam int RAM_DEPTH = 1 << RAM_AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } ch_state_e;
endpackage

// File: rtl/bs_msg_ram.sv
// 512x32 simple dual-port RAM: byte-enabled write port, registered read-first read port.
module bs_msg_ram
    import bs_pkg::RAM_AW, bs_pkg::RAM_DEPTH;
(
    input  logic              s_axi_aclk,
    input  logic [3:0]        wr_be,
    input  logic [RAM_AW-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    input  logic [RAM_AW-1:0] rd_addr,
    output logic [31:0]       rd_data
);
    logic [31:0] mem [RAM_DEPTH];

    always_ff @(posedge s_axi_aclk) begin
        for (int unsigned k = 0; k < 4; k++) begin
            if (wr_be[k]) mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
        end
    end

    // Non-blocking write above leaves the old word visible to a same-cycle read.
    always_ff @(posedge s_axi_aclk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/bs_msg_buffer.sv
// Per-channel bit-serial message playback from a shared word RAM with
// round-robin prefetch into a two-word (cur/nxt) buffer per channel.
module bs_msg_buffer
    import bs_pkg::ch_state_e, bs_pkg::IDLE, bs_pkg::PRIME, bs_pkg::RUN,
           bs_pkg::CH_W, bs_pkg::WORD_W, bs_pkg::RAM_AW;
#(
    parameter int NUM_CH    = bs_pkg::NUM_CH,
    parameter int MSG_WORDS = bs_pkg::MSG_WORDS
)(
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    input  logic              msg_wr_en,
    input  logic [3:0]        msg_wr_strb,
    input  logic [2:0]        msg_channel,
    input  logic [7:0]        msg_offset,
    input  logic [31:0]       msg_data,
    input  logic [NUM_CH-1:0] channel_enable,
    input  logic [NUM_CH-1:0] frame_start,
    input  logic [NUM_CH-1:0] bit_adv,
    output logic [NUM_CH-1:0] ch_bit,
    output logic [NUM_CH-1:0] ch_ready,
    output logic [NUM_CH-1:0] underrun
);
    ch_state_e         state     [NUM_CH];
    logic [31:0]       cur_word  [NUM_CH];
    logic [31:0]       nxt_word  [NUM_CH];
    logic [WORD_W-1:0] fetch_ptr [NUM_CH];
    logic [4:0]        bit_idx   [NUM_CH];
    logic [NUM_CH-1:0] cur_valid, nxt_valid, in_flight, gen, req, land, roll;
    logic [CH_W-1:0]   rr_ptr, cand, grant_ch, fetch_ch;
    logic              grant_vld, fetch_vld, fetch_gen;
    logic [31:0]       rd_data;
    logic [3:0]        wr_be;

    assign wr_be = (msg_wr_en && msg_offset[7:6] == 2'b00) ? msg_wr_strb : '0;

    bs_msg_ram u_ram (
        .s_axi_aclk (s_axi_aclk),
        .wr_be      (wr_be),
        .wr_addr    ({msg_channel, msg_offset[5:0]}),
        .wr_data    (msg_data),
        .rd_en      (grant_vld),
        .rd_addr    (RAM_AW'({grant_ch, fetch_ptr[grant_ch]})),
        .rd_data    (rd_data)
    );

    always_comb begin
        req      = '0;
        ch_ready = '0;
        ch_bit   = '0;
        land     = '0;
        roll     = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            req[c]      = (state[c] != IDLE) && !in_flight[c] && !(cur_valid[c] && nxt_valid[c]);
            ch_ready[c] = cur_valid[c] && (state[c] == RUN);
            ch_bit[c]   = ch_ready[c] && cur_word[c][bit_idx[c]];
            // Generation tag drops data fetched before the latest frame_start.
            land[c]     = fetch_vld && (fetch_ch == CH_W'(c)) && (fetch_gen == gen[c]);
            roll[c]     = bit_adv[c] && ch_ready[c] && (bit_idx[c] == 5'd31);
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = rr_ptr + CH_W'(i);
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_ch  = cand;
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rr_ptr    <= '0;
            fetch_vld <= 1'b0;
            fetch_ch  <= '0;
            fetch_gen <= 1'b0;
        end else begin
            fetch_vld <= grant_vld;
            if (grant_vld) begin
                fetch_ch  <= grant_ch;
                fetch_gen <= gen[grant_ch];
                rr_ptr    <= grant_ch + CH_W'(1);
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                state[c]     <= IDLE;
                cur_word[c]  <= '0;
                nxt_word[c]  <= '0;
                fetch_ptr[c] <= '0;
                bit_idx[c]   <= '0;
            end
            cur_valid <= '0;
            nxt_valid <= '0;
            in_flight <= '0;
            gen       <= '0;
            underrun  <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (!channel_enable[c]) begin
                    state[c]     <= IDLE;
                    cur_valid[c] <= 1'b0;
                    nxt_valid[c] <= 1'b0;
                    in_flight[c] <= 1'b0;
                    underrun[c]  <= 1'b0;
                    bit_idx[c]   <= '0;
                    fetch_ptr[c] <= '0;
                end else if (frame_start[c]) begin
                    state[c]     <= PRIME;
                    gen[c]       <= ~gen[c];
                    cur_valid[c] <= 1'b0;
                    nxt_valid[c] <= 1'b0;
                    in_flight[c] <= 1'b0;
                    underrun[c]  <= 1'b0;
                    bit_idx[c]   <= '0;
                    fetch_ptr[c] <= '0;
                end else if (state[c] != IDLE) begin
                    if (grant_vld && grant_ch == CH_W'(c)) begin
                        in_flight[c] <= 1'b1;
                        fetch_ptr[c] <= (fetch_ptr[c] == WORD_W'(MSG_WORDS - 1)) ? '0
                                                                                  : fetch_ptr[c] + WORD_W'(1);
                    end else if (land[c]) begin
                        in_flight[c] <= 1'b0;
                    end
                    if (bit_adv[c] && !ch_ready[c]) underrun[c] <= 1'b1;
                    if (bit_adv[c] && ch_ready[c]) bit_idx[c] <= bit_idx[c] + 5'd1;
                    // A word landing on a starved rollover goes straight to cur.
                    if (roll[c]) begin
                        if (nxt_valid[c]) begin
                            cur_word[c] <= nxt_word[c];
                            if (land[c]) nxt_word[c] <= rd_data;
                            else         nxt_valid[c] <= 1'b0;
                        end else begin
                            underrun[c] <= 1'b1;
                            if (land[c]) cur_word[c]  <= rd_data;
                            else         cur_valid[c] <= 1'b0;
                        end
                    end else if (land[c]) begin
                        if (!cur_valid[c]) begin
                            cur_word[c]  <= rd_data;
                            cur_valid[c] <= 1'b1;
                        end else begin
                            nxt_word[c]  <= rd_data;
                            nxt_valid[c] <= 1'b1;
                        end
                    end
                    if (state[c] == PRIME && land[c]) state[c] <= RUN;
                end
            end
        end
    end
endmodule

// File: tb/tb_bs_msg_buffer.sv
// Self-checking bench for bs_msg_buffer: vector table, directed corner sequences,
// and randomized playback against a word-array reference model.
module tb_bs_msg_buffer;
    logic        s_axi_aclk = 1'b0;
    logic        s_axi_aresetn = 1'b0;
    logic        msg_wr_en = 1'b0;
    logic [3:0]  msg_wr_strb = '0;
    logic [2:0]  msg_channel = '0;
    logic [7:0]  msg_offset = '0;
    logic [31:0] msg_data = '0;
    logic [7:0]  channel_enable = '0;
    logic [7:0]  frame_start = '0;
    logic [7:0]  bit_adv = '0;
    logic [7:0]  ch_bit, ch_ready, underrun;

    bs_msg_buffer #(.NUM_CH(8), .MSG_WORDS(64)) dut (
        .s_axi_aclk     (s_axi_aclk),
        .s_axi_aresetn  (s_axi_aresetn),
        .msg_wr_en      (msg_wr_en),
        .msg_wr_strb    (msg_wr_strb),
        .msg_channel    (msg_channel),
        .msg_offset     (msg_offset),
        .msg_data       (msg_data),
        .channel_enable (channel_enable),
        .frame_start    (frame_start),
        .bit_adv        (bit_adv),
        .ch_bit         (ch_bit),
        .ch_ready       (ch_ready),
        .underrun       (underrun)
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    typedef struct {
        int          ch;
        logic [7:0]  off;
        logic [3:0]  strb;
        logic [31:0] data;
        logic [31:0] exp;
    } wr_vec_t;

    int            tests = 0;
    int            fails = 0;
    logic [31:0]   model_mem [8][64];
    logic [2111:0] capbits;
    logic          cap_ok;
    wr_vec_t       tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input int ch, input logic [7:0] off, input logic [3:0] strb, input logic [31:0] data);
        msg_wr_en   = 1'b1;
        msg_channel = 3'(ch);
        msg_offset  = off;
        msg_wr_strb = strb;
        msg_data    = data;
        if (off[7:6] == 2'b00) begin
            for (int k = 0; k < 4; k++)
                if (strb[k]) model_mem[ch][off[5:0]][8*k +: 8] = data[8*k +: 8];
        end
        @(negedge s_axi_aclk);
        msg_wr_en = 1'b0;
    endtask

    task automatic start(input logic [7:0] m);
        channel_enable = channel_enable | m;
        frame_start    = m;
        @(negedge s_axi_aclk);
        frame_start = '0;
    endtask

    task automatic do_reset();
        channel_enable = '0;
        frame_start    = '0;
        bit_adv        = '0;
        s_axi_aresetn  = 1'b0;
        @(negedge s_axi_aclk);
        s_axi_aresetn = 1'b1;
        @(negedge s_axi_aclk);
    endtask

    // Sample nbits from one channel, pulsing bit_adv every gap cycles once ready.
    task automatic capture(input int ch, input int nbits, input int gap);
        int t;
        cap_ok  = 1'b1;
        capbits = '0;
        for (int n = 0; n < nbits && cap_ok; n++) begin
            t = 0;
            while (!ch_ready[ch] && t < 64) begin
                @(negedge s_axi_aclk);
                t++;
            end
            if (!ch_ready[ch]) begin
                check($sformatf("ready_timeout_ch%0d", ch), {31'b0, ch_ready[ch]}, 32'd1);
                cap_ok = 1'b0;
            end else begin
                capbits[n]  = ch_bit[ch];
                bit_adv[ch] = 1'b1;
                @(negedge s_axi_aclk);
                bit_adv[ch] = 1'b0;
                repeat (gap - 1) @(negedge s_axi_aclk);
            end
        end
    endtask

    function automatic logic [31:0] capword(input int w);
        return capbits[w*32 +: 32];
    endfunction

    function automatic logic mbit(input int ch, input int n);
        return model_mem[ch][(n / 32) % 64][n % 32];
    endfunction

    // Independent per-channel bit_adv schedules; gap==0 means random spacing 18..30.
    task automatic run_multi(input logic [7:0] mask, input int ncyc, input int gap, input int first);
        int cnt [8];
        int err [8];
        int nb  [8];
        logic [7:0] adv;
        for (int c = 0; c < 8; c++) begin
            cnt[c] = first;
            err[c] = 0;
            nb[c]  = 0;
        end
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            adv = '0;
            for (int c = 0; c < 8; c++) begin
                if (mask[c]) begin
                    if (cnt[c] == 0) begin
                        if (ch_ready[c]) begin
                            if (ch_bit[c] !== mbit(c, nb[c])) err[c]++;
                            nb[c]++;
                            adv[c] = 1'b1;
                        end else begin
                            err[c]++;
                        end
                        cnt[c] = (gap != 0) ? gap - 1 : int'($urandom_range(17, 29));
                    end else begin
                        cnt[c]--;
                    end
                end
            end
            bit_adv = adv;
            @(negedge s_axi_aclk);
        end
        bit_adv = '0;
        for (int c = 0; c < 8; c++) begin
            if (mask[c]) begin
                check($sformatf("multi_bit_errors_ch%0d", c), 32'(err[c]), 32'd0);
                check($sformatf("multi_underrun_ch%0d", c), {31'b0, underrun[c]}, 32'd0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [7:0] mask;

        repeat (3) @(negedge s_axi_aclk);
        check("reset_ch_ready", 32'(ch_ready), 32'd0);
        check("reset_ch_bit", 32'(ch_bit), 32'd0);
        check("reset_underrun", 32'(underrun), 32'd0);
        s_axi_aresetn = 1'b1;
        @(negedge s_axi_aclk);

        for (int c = 0; c < 8; c++)
            for (int w = 0; w < 64; w++)
                wr(c, 8'(w), 4'hF, $urandom);

        // Byte-enable and out-of-range offset writes, read back through playback.
        tbl[0] = '{0, 8'h05, 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[1] = '{0, 8'h05, 4'b0010, 32'h0000_0000, 32'hFFFF_00FF};
        tbl[2] = '{0, 8'h45, 4'b1111, 32'h1234_5678, 32'hFFFF_00FF};
        tbl[3] = '{0, 8'h05, 4'b0101, 32'h1122_3344, 32'hFF22_0044};
        for (int i = 0; i < 4; i++) begin
            wr(tbl[i].ch, tbl[i].off, tbl[i].strb, tbl[i].data);
            start(8'h01);
            capture(0, 6 * 32, 3);
            check($sformatf("tbl%0d_word5", i), capword(5), tbl[i].exp);
            channel_enable[0] = 1'b0;
            @(negedge s_axi_aclk);
        end

        // Full message wrap on channel 2 at 20-cycle bit spacing.
        for (int w = 0; w < 64; w++) wr(2, 8'(w), 4'hF, 32'(w));
        start(8'h04);
        capture(2, 65 * 32, 20);
        for (int w = 0; w < 65; w++)
            check($sformatf("ch2_word%0d", w), capword(w), model_mem[2][w % 64]);
        check("ch2_underrun", {31'b0, underrun[2]}, 32'd0);
        channel_enable[2] = 1'b0;
        @(negedge s_axi_aclk);

        // Starvation by back-to-back bit_adv, then recovery by frame_start.
        start(8'h02);
        bit_adv[1] = 1'b1;
        repeat (64) @(negedge s_axi_aclk);
        bit_adv[1] = 1'b0;
        check("ch1_underrun_set", {31'b0, underrun[1]}, 32'd1);
        frame_start[1] = 1'b1;
        @(negedge s_axi_aclk);
        frame_start = '0;
        check("ch1_underrun_clr", {31'b0, underrun[1]}, 32'd0);
        t = 1;
        while (!ch_ready[1] && t < 4) begin
            @(negedge s_axi_aclk);
            t++;
        end
        check("ch1_ready_within_4", {31'b0, ch_ready[1]}, 32'd1);
        check("ch1_first_bit", {31'b0, ch_bit[1]}, {31'b0, model_mem[1][0][0]});
        capture(1, 32, 3);
        check("ch1_word0", capword(0), model_mem[1][0]);
        channel_enable[1] = 1'b0;
        @(negedge s_axi_aclk);

        // frame_start colliding with bit_adv mid-frame, then disable.
        start(8'h08);
        capture(3, 45, 3);
        frame_start[3] = 1'b1;
        bit_adv[3]     = 1'b1;
        @(negedge s_axi_aclk);
        frame_start = '0;
        bit_adv     = '0;
        check("ch3_restart_not_ready", {31'b0, ch_ready[3]}, 32'd0);
        check("ch3_restart_underrun", {31'b0, underrun[3]}, 32'd0);
        capture(3, 32, 3);
        check("ch3_restart_word0", capword(0), model_mem[3][0]);
        channel_enable[3] = 1'b0;
        @(negedge s_axi_aclk);
        check("ch3_disabled_ready", {31'b0, ch_ready[3]}, 32'd0);
        check("ch3_disabled_bit", {31'b0, ch_bit[3]}, 32'd0);

        // All channels started together: grant rotation from channel 0, then sustained playback.
        do_reset();
        start(8'hFF);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("grant_order%0d", k), {28'b0, dut.grant_vld, dut.grant_ch}, {28'b0, 1'b1, 3'(k)});
            @(negedge s_axi_aclk);
        end
        run_multi(8'hFF, 66 * 18, 18, 10);
        channel_enable = '0;
        @(negedge s_axi_aclk);

        // Asynchronous reset pulse in the middle of playback.
        start(8'h30);
        capture(4, 40, 3);
        check("pre_reset_ready4", {31'b0, ch_ready[4]}, 32'd1);
        #3 s_axi_aresetn = 1'b0;
        #1;
        check("async_reset_ready", 32'(ch_ready), 32'd0);
        check("async_reset_bit", 32'(ch_bit), 32'd0);
        check("async_reset_underrun", 32'(underrun), 32'd0);
        @(negedge s_axi_aclk);
        s_axi_aresetn = 1'b1;
        repeat (20) @(negedge s_axi_aclk);
        check("post_reset_idle_ready", 32'(ch_ready), 32'd0);
        start(8'h10);
        capture(4, 32, 3);
        check("post_reset_word0", capword(0), model_mem[4][0]);
        channel_enable = '0;
        @(negedge s_axi_aclk);

        // Randomized writes (including ignored offsets) and random channel subsets.
        for (int r = 0; r < 2; r++) begin
            repeat (300) wr(int'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 4'($urandom), $urandom);
            mask = 8'($urandom_range(1, 255));
            start(mask);
            run_multi(mask, 3000, 0, 12);
            channel_enable = '0;
            @(negedge s_axi_aclk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bs_msg_buffer.md
BS_MSG_BUFFER -- requirements
Module: bs_msg_buffer

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of channels.
REQ-002 SHALL have parameter MSG_WORDS, default 64: 32-bit words per channel message, which is 2048 bits.
REQ-003 SHALL have port s_axi_aclk, input, width 1: clock; all logic on its rising edge.
REQ-004 SHALL have port s_axi_aresetn, input, width 1: reset, asynchronous, active-low.
REQ-005 SHALL have port msg_wr_en, input, width 1: one-cycle message word write pulse.
REQ-006 SHALL have port msg_wr_strb, input, width 4: byte enables; bit k enables byte k.
REQ-007 SHALL have port msg_channel, input, width 3: target channel of the write.
REQ-008 SHALL have port msg_offset, input, width 8: word index within the channel buffer.
REQ-009 SHALL have port msg_data, input, width 32: write data.
REQ-010 SHALL have port channel_enable, input, width 8: per-channel run enable (level).
REQ-011 SHALL have port frame_start, input, width 8: per-channel pulse that restarts the channel at bit 0.
REQ-012 SHALL have port bit_adv, input, width 8: per-channel pulse that advances to the next bit.
REQ-013 SHALL have port ch_bit, output, width 8: current message bit per channel.
REQ-014 SHALL have port ch_ready, output, width 8: ch_bit is valid.
REQ-015 SHALL have port underrun, output, width 8: sticky per-channel starvation flag.

Function
REQ-016 Writes: msg_wr_en SHALL write the enabled bytes of msg_data into word msg_offset[5:0] of channel msg_channel at that edge; writes with msg_offset[7:6]!=0 SHALL be ignored.
REQ-017 Buffer: one shared 512x32 simple dual-port RAM; address {channel, offset}; a read at a word being written in the same cycle SHALL return the old data (read-first).
REQ-018 Per-channel state: cur_word plus cur_valid, nxt_word plus nxt_valid, 6-bit fetch pointer, 5-bit bit_idx.
REQ-019 Per-channel FSM states: IDLE, PRIME, RUN.
REQ-020 IDLE SHALL be entered when the channel is disabled, with cur_valid, nxt_valid and underrun all 0.
REQ-021 IDLE->PRIME SHALL occur on frame_start while enabled; PRIME SHALL clear underrun, set pointer=0 and bit_idx=0, and invalidate both words.
REQ-022 PRIME->RUN SHALL occur when cur_valid=1.
REQ-023 A channel SHALL request a RAM read whenever it is not IDLE, has no fetch in flight, and !(cur_valid && nxt_valid).
REQ-024 Read arbiter: round-robin among requesters, one grant per cycle; after a grant, the granted channel SHALL have the lowest priority next.
REQ-025 Read latency: grant in cycle c, RAM address registered at the end of c, data loaded at the end of c+1 into cur_word if !cur_valid, else into nxt_word; pointer SHALL increment modulo MSG_WORDS (63->0 wraps).
REQ-026 Output: ch_bit[ch] SHALL equal cur_word[bit_idx] (LSB first, words ascending); ch_ready[ch] SHALL equal cur_valid && state==RUN; when ch_ready=0, ch_bit SHALL be 0.
REQ-027 bit_adv with ch_ready=1: bit_idx SHALL increment.
REQ-028 bit_adv at bit_idx=31: cur_word SHALL take nxt_word if nxt_valid, otherwise cur_valid SHALL clear and underrun SHALL set; bit_idx SHALL wrap to 0 in both cases.
REQ-029 After an underrun, the next fetched word SHALL become cur_word at bit 0, with no bit replay.
REQ-030 bit_adv while ch_ready=0 SHALL set underrun and SHALL be otherwise ignored.
REQ-031 Simultaneous frame_start and bit_adv: frame_start SHALL win. An in-flight fetch at frame_start SHALL be discarded (tag by generation bit).
REQ-032 Deassertion of channel_enable SHALL force IDLE on the next edge regardless of other inputs; frame_start while disabled SHALL be ignored.
REQ-033 Sustained throughput: bit_adv spacing of at least 2*NUM_CH+2 cycles on all channels SHALL never underrun once RUN is reached.

Reset
REQ-034 On reset assertion, all channels SHALL go to IDLE; ch_bit, ch_ready and underrun SHALL be 0; arbiter pointer SHALL be channel 0; no fetch in flight.
REQ-035 RAM contents SHALL NOT be reset; reset mid-frame SHALL discard all prefetched words; the next frame_start after release SHALL re-prime from word 0.

Structure
REQ-036 Package bs_pkg SHALL hold NUM_CH, MSG_WORDS, the ch_state_e enum (IDLE/PRIME/RUN), and the RAM address width.
REQ-037 Sub-module bs_msg_ram SHALL be a 512x32 read-first simple dual-port RAM with byte write enables and a registered read; the arbiter and per-channel FSMs SHALL stay in bs_msg_buffer.

Verification
REQ-038 Write ch2 words 0..63 = 0x0000_0000+i, enable ch2, pulse frame_start[2], bit_adv every 20 cycles -> ch_bit sequence matches words LSB first, word 63 followed by word 0 again, underrun[2]=0.
REQ-039 Write ch0 off 5 = 0xFFFF_FFFF, then strb=0b0010 data 0x0000_0000 -> word reads 0xFFFF_00FF; write with msg_offset=0x40 -> no RAM change.
REQ-040 All 8 channels started the same cycle, bit_adv every 18 cycles -> no underrun, grants rotate 0..7 with no channel granted twice before all requesters served.
REQ-041 ch1 bit_adv every cycle -> underrun[1]=1 by bit 64; frame_start[1] -> underrun clears, bit 0 of word 0 presented within 4 cycles.
REQ-042 frame_start[3] and bit_adv[3] same cycle mid-frame; then channel_enable[3]=0 -> restart from bit 0 of word 0; then ch_ready[3]=0, ch_bit[3]=0 next cycle.
REQ-043 Async reset pulse mid-RUN -> all outputs 0 immediately; after release, ch_ready stays 0 until a new frame_start.
